// File: rtl/pe_loader_pkg.sv
// pe_loader_pkg: shared widths and FSM encodings for the PE loader
package pe_loader_pkg;
  localparam int REG_NUM    = 4;
  localparam int INST_WIDTH = 16;
  localparam int DATA_WIDTH = 16;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INST  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_BURST = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
endpackage

// File: rtl/ld_buffer.sv
// ld_buffer: DEPTH-deep synchronous FIFO with combinational head read
module ld_buffer #(
  parameter int DEPTH = 8,
  parameter int W = 32,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [W-1:0]  wdata,
  input  logic          rd,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign rdata = mem[rp];
  assign empty = count == '0;
  assign full  = count == CW'(DEPTH);
  always_ff @(posedge clk)
    if (wr) mem[wp] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp == AW'(DEPTH - 1) ? '0 : wp + AW'(1);
      if (rd) rp <= rp == AW'(DEPTH - 1) ? '0 : rp + AW'(1);
      count <= count + CW'(wr) - CW'(rd);
    end
endmodule

// File: rtl/pe_loader.sv
// pe_loader: streams instructions and a data burst from a host into a PE, then times its run
module pe_loader import pe_loader_pkg::*; #(
  parameter int BURST = REG_NUM * 2,
  parameter int CNT_W = 16
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [7:0]              n_inst,
  input  logic [7:0]              n_iter,
  input  logic [CNT_W-1:0]        iter_len,
  input  logic                    s_valid,
  input  logic [31:0]             s_data,
  output logic                    s_ready,
  output logic                    inst_in_v,
  output logic [INST_WIDTH-1:0]   inst_in,
  output logic                    din_pe_v,
  output logic [DATA_WIDTH*2-1:0] din_pe,
  output logic                    alpha_v,
  output logic                    busy,
  output logic                    done
);
  localparam int RW = CNT_W + 8;
  localparam int BW = $clog2(BURST + 1);
  logic [2:0] state, nxt;
  logic [7:0] n_inst_q, n_iter_q, icnt, icnt_nxt;
  logic [CNT_W-1:0] iter_len_q;
  logic [RW-1:0] total, run_cnt, run_nxt;
  logic [BW-1:0] bcnt, bcnt_nxt, fcount;
  logic xfer, wr, rd, empty, full;
  logic [DATA_WIDTH*2-1:0] rd_data;
  assign total = RW'(n_iter_q) * RW'(iter_len_q);
  assign xfer  = s_valid & s_ready;
  assign wr    = xfer && state == S_DATA && !full;
  // the first burst read overlaps the final write so the PE sees no gap
  assign rd    = nxt == S_BURST && !empty;
  ld_buffer #(.DEPTH(BURST), .W(DATA_WIDTH*2)) u_buf (
    .clk(clk), .rst_n(rst_n), .wr(wr), .wdata(s_data[DATA_WIDTH*2-1:0]),
    .rd(rd), .rdata(rd_data), .count(fcount), .empty(empty), .full(full)
  );
  always_comb begin
    nxt      = state;
    icnt_nxt = icnt;
    bcnt_nxt = bcnt;
    run_nxt  = run_cnt;
    case (state)
      S_IDLE: if (start) begin
        nxt      = n_inst == '0 ? S_DATA : S_INST;
        icnt_nxt = '0;
      end
      S_INST: if (xfer) begin
        icnt_nxt = icnt + 8'd1;
        if (icnt_nxt == n_inst_q) nxt = S_DATA;
      end
      S_DATA: if (wr && fcount == BW'(BURST - 1)) begin
        nxt      = S_BURST;
        bcnt_nxt = BW'(1);
      end
      S_BURST: if (bcnt == BW'(BURST)) begin
        nxt     = total == '0 ? S_DONE : S_RUN;
        run_nxt = '0;
      end else bcnt_nxt = bcnt + BW'(1);
      S_RUN: if (run_cnt == total - RW'(1)) nxt = S_DONE;
             else run_nxt = run_cnt + RW'(1);
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= S_IDLE;
      icnt       <= '0;
      bcnt       <= '0;
      run_cnt    <= '0;
      n_inst_q   <= '0;
      n_iter_q   <= '0;
      iter_len_q <= '0;
      s_ready    <= 1'b0;
      inst_in_v  <= 1'b0;
      inst_in    <= '0;
      din_pe_v   <= 1'b0;
      din_pe     <= '0;
      alpha_v    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state   <= nxt;
      icnt    <= icnt_nxt;
      bcnt    <= bcnt_nxt;
      run_cnt <= run_nxt;
      if (state == S_IDLE && start) begin
        n_inst_q   <= n_inst;
        n_iter_q   <= n_iter;
        iter_len_q <= iter_len;
      end
      s_ready   <= nxt == S_INST || nxt == S_DATA;
      inst_in_v <= state == S_INST && xfer;
      inst_in   <= state == S_INST && xfer ? s_data[INST_WIDTH-1:0] : '0;
      din_pe_v  <= rd;
      din_pe    <= rd ? rd_data : '0;
      alpha_v   <= nxt == S_RUN && run_nxt >= total - RW'(iter_len_q);
      busy      <= nxt != S_IDLE;
      done      <= nxt == S_DONE;
    end
endmodule

// File: tb/tb_pe_loader.sv
// tb_pe_loader: table-driven load/run sequences plus reset and restart corner cases
module tb_pe_loader;
  import pe_loader_pkg::*;
  localparam int BURST = REG_NUM * 2;
  logic clk = 0, rst_n = 0, start = 0, s_valid = 0;
  logic [7:0] n_inst = 0, n_iter = 0;
  logic [15:0] iter_len = 0;
  logic [31:0] s_data = 0;
  logic s_ready, inst_in_v, din_pe_v, alpha_v, busy, done;
  logic [INST_WIDTH-1:0] inst_in;
  logic [DATA_WIDTH*2-1:0] din_pe;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [7:0]  ni;
    logic [7:0]  nt;
    logic [15:0] il;
    bit          tog;
    bit          sir;
    int          exp_run;
    int          exp_alpha;
  } vec_t;
  vec_t tbl[5];
  pe_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_inst(n_inst), .n_iter(n_iter),
    .iter_len(iter_len), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .inst_in_v(inst_in_v), .inst_in(inst_in), .din_pe_v(din_pe_v), .din_pe(din_pe),
    .alpha_v(alpha_v), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] word(input int k, input int ni);
    return k < ni ? 32'hFFFF_00A1 + 32'(k) : 32'h5A00_0000 + 32'(k - ni) * 32'h0000_0101;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run_seq(input vec_t v);
    int cyc = 0, sent = 0, xfers = 0, need, dfirst = -1, dlast = -1;
    int acnt = 0, afirst = -1, alast = -1, dn = 0, done_cyc = -1, zviol = 0;
    bit pend = 0, pi, sir_done = 0;
    logic [31:0] w, dq[$];
    logic [15:0] expv;
    need = int'(v.ni) + BURST;
    start = 1; n_inst = v.ni; n_iter = v.nt; iter_len = v.il; s_valid = 0;
    @(posedge clk); #1;
    start = 0; n_inst = 8'd9; n_iter = 8'd9; iter_len = 16'd9;
    chk("busy_after_start", busy, 1);
    while (cyc < 1000) begin
      pi = 0;
      if (pend) begin
        xfers++;
        if (sent < int'(v.ni)) begin
          pi = 1;
          w = word(sent, v.ni);
          expv = w[15:0];
        end
        sent++;
        if (sent == need) chk("s_ready_low_after_burst", s_ready, 0);
      end
      if (inst_in_v || pi) chk("inst_v", inst_in_v, pi);
      if (pi) chk("inst_val", inst_in, expv);
      if (!inst_in_v && inst_in != 0) zviol++;
      if (din_pe_v) begin
        if (dfirst < 0) dfirst = cyc;
        dlast = cyc;
        dq.push_back(din_pe);
      end else if (din_pe != 0) zviol++;
      if (alpha_v) begin
        acnt++;
        if (afirst < 0) afirst = cyc;
        alast = cyc;
      end
      if (done) begin
        dn++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc > done_cyc) chk("busy_idle", busy, 0);
      if (done_cyc >= 0 && cyc == done_cyc + 2) break;
      start = 0;
      if (v.sir && dfirst >= 0 && !din_pe_v && done_cyc < 0 && !sir_done) begin
        start = 1;
        sir_done = 1;
      end
      if (sent < need) begin
        s_valid = v.tog ? (cyc % 2) == 0 : 1'b1;
        s_data = word(sent, v.ni);
      end else begin
        s_valid = 1;
        s_data = 32'hDEAD_BEEF;
      end
      pend = s_valid && s_ready;
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 0;
    start = 0;
    chk("timeout", done_cyc >= 0, 1);
    chk("xfers", xfers, need);
    chk("din_count", dq.size(), BURST);
    chk("din_contig", dlast - dfirst + 1, BURST);
    foreach (dq[i]) chk("din_order", dq[i], word(int'(v.ni) + i, v.ni));
    chk("run_len", done_cyc - dlast - 1, v.exp_run);
    chk("alpha_cnt", acnt, v.exp_alpha);
    if (v.exp_alpha > 0) begin
      chk("alpha_end", alast, done_cyc - 1);
      chk("alpha_contig", alast - afirst + 1, v.exp_alpha);
    end
    chk("done_pulses", dn, 1);
    chk("zero_when_invalid", zviol, 0);
  endtask
  initial begin
    int dc;
    tbl[0] = '{ni: 3, nt: 4, il: 5, tog: 0, sir: 0, exp_run: 20, exp_alpha: 5};
    tbl[1] = '{ni: 0, nt: 0, il: 7, tog: 1, sir: 0, exp_run: 0,  exp_alpha: 0};
    tbl[2] = '{ni: 2, nt: 3, il: 0, tog: 1, sir: 0, exp_run: 0,  exp_alpha: 0};
    tbl[3] = '{ni: 1, nt: 2, il: 3, tog: 0, sir: 1, exp_run: 6,  exp_alpha: 3};
    tbl[4] = '{ni: 5, nt: 1, il: 1, tog: 1, sir: 0, exp_run: 1,  exp_alpha: 1};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {s_ready, inst_in_v, inst_in, din_pe_v, din_pe, alpha_v, busy, done}, 0);
    rst_n = 1;
    for (int i = 0; i < 5; i++) run_seq(tbl[i]);
    start = 1; n_inst = 0; n_iter = 1; iter_len = 2;
    @(posedge clk); #1;
    start = 0;
    s_valid = 1;
    dc = 0;
    for (int k = 0; k < 100 && dc < 2; k++) begin
      s_data = 32'h1234_0000 + 32'(k);
      @(posedge clk); #1;
      if (din_pe_v) dc++;
    end
    chk("reached_burst", dc, 2);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_burst", {s_ready, inst_in_v, inst_in, din_pe_v, din_pe, alpha_v, busy, done}, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_held", {s_ready, inst_in_v, inst_in, din_pe_v, din_pe, alpha_v, busy, done}, 0);
    s_valid = 0;
    rst_n = 1;
    run_seq(tbl[0]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
